// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32IM ALU control slice: op codes, ALU_Op classes,
// funct7 selectors and the MDU sequencing FSM states.
package alu_ctrl_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_SRL  = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SRA  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SLT  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SLTU = 5'b00111;
    localparam logic [OP_W-1:0] OP_LUI  = 5'b01000;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01001;
    localparam logic [OP_W-1:0] OP_SLL  = 5'b01100;
    // M ops are OP_MUL with funct3 in the low three bits
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;

    localparam logic [2:0] CLS_R  = 3'b000;
    localparam logic [2:0] CLS_I  = 3'b001;
    localparam logic [2:0] CLS_U  = 3'b010;
    localparam logic [2:0] CLS_LS = 3'b011;
    localparam logic [2:0] CLS_B  = 3'b100;
    localparam logic [2:0] CLS_J  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of {ALU_Op class, funct7, funct3} into an ALU op code,
// an illegal-encoding flag and the M-extension indicator.
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic                valid,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [6:0]          funct7,
    input  logic [2:0]          funct3,
    output logic [OP_W-1:0]     op,
    output logic                illegal,
    output logic                is_m
);

    logic [OP_W-1:0] base_op;
    logic            bad;
    logic            cls_ok;

    // class codes only use the low three bits; anything above them is unsupported
    assign cls_ok = (alu_op >> 3) == '0;

    always_comb begin
        base_op = OP_ADD;
        case (funct3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    end

    always_comb begin
        op  = OP_ADD;
        bad = 1'b0;
        if (!cls_ok) begin
            bad = 1'b1;
        end else begin
            case (alu_op[2:0])
                CLS_R: begin
                    if (funct7 == F7_BASE)                         op = base_op;
                    else if (funct7 == F7_ALT && funct3 == 3'b000) op = OP_SUB;
                    else if (funct7 == F7_ALT && funct3 == 3'b101) op = OP_SRA;
                    else if (funct7 == F7_MEXT)                    op = OP_MUL | OP_W'(funct3);
                    else                                           bad = 1'b1;
                end
                CLS_I: begin
                    case (funct3)
                        3'b001: begin
                            if (funct7 == F7_BASE) op = OP_SLL;
                            else                   bad = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     op = OP_SRL;
                            else if (funct7 == F7_ALT) op = OP_SRA;
                            else                       bad = 1'b1;
                        end
                        default: op = base_op;
                    endcase
                end
                CLS_U:        op = OP_LUI;
                CLS_LS, CLS_J: op = OP_ADD;
                CLS_B: begin
                    case (funct3[2:1])
                        2'b00:   op = OP_SUB;
                        2'b10:   op = OP_SLT;
                        2'b11:   op = OP_SLTU;
                        default: bad = 1'b1;
                    endcase
                end
                default: bad = 1'b1;
            endcase
        end
    end

    assign illegal = valid & bad;
    assign is_m    = valid & cls_ok & (alu_op[2:0] == CLS_R) & (funct7 == F7_MEXT);

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control: combinational decode for single-cycle ops plus an FSM
// that sequences M-extension ops through the external MDU with a watchdog.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W       = 3,
    parameter int unsigned ALU_CTRL_W     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [ALU_OP_W-1:0]   ALU_Op_i,
    input  logic [6:0]            funct7_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mdu_done_i,
    output logic [ALU_CTRL_W-1:0] ALU_Operation_o,
    output logic                  mdu_start_o,
    output logic                  mdu_abort_o,
    output logic                  stall_o,
    output logic                  wb_sel_mdu_o,
    output logic                  illegal_o,
    output logic                  timeout_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  dec_op, op_q;
    logic             dec_illegal, dec_is_m;
    logic             issue, wd_hit;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    alu_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
        .valid   (valid_i),
        .alu_op  (ALU_Op_i),
        .funct7  (funct7_i),
        .funct3  (funct3_i),
        .op      (dec_op),
        .illegal (dec_illegal),
        .is_m    (dec_is_m)
    );

    assign issue  = dec_is_m & ~flush_i;
    assign wd_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue) state_d = ST_WAIT;
            ST_WAIT: begin
                if (flush_i)                state_d = ST_IDLE;
                else if (mdu_done_i || wd_hit) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // all outputs, including the otherwise combinational decode, are held at zero during reset
    always_comb begin
        ALU_Operation_o = '0;
        mdu_start_o     = 1'b0;
        mdu_abort_o     = 1'b0;
        stall_o         = 1'b0;
        wb_sel_mdu_o    = 1'b0;
        illegal_o       = 1'b0;
        if (reset) begin
            illegal_o = dec_illegal;
            case (state_q)
                ST_IDLE: begin
                    ALU_Operation_o = ALU_CTRL_W'(dec_op);
                    mdu_start_o     = issue;
                    stall_o         = issue;
                end
                ST_WAIT: begin
                    ALU_Operation_o = ALU_CTRL_W'(op_q);
                    stall_o         = 1'b1;
                    mdu_abort_o     = flush_i | (~mdu_done_i & wd_hit);
                end
                ST_DONE: begin
                    ALU_Operation_o = ALU_CTRL_W'(op_q);
                    wb_sel_mdu_o    = ~flush_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && issue) begin
                op_q  <= dec_op;
                cnt_q <= '0;
            end else if (state_q == ST_WAIT && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // done and flush both take precedence over the watchdog
            if (state_q == ST_WAIT && !flush_i && !mdu_done_i && wd_hit)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Next-generation ALU control for the RV32 core.
- Decodes the ALU_Op class, funct3 and the full funct7 into a widened ALU operation code covering RV32I plus the M extension.
- Adds an FSM that sequences multi-cycle MUL/DIV/REM operations through an external multiply/divide unit (MDU), with start/done handshake, pipeline stall, flush abort and a watchdog timeout.
- Sits in the EX stage between the main control unit, the ALU and the MDU.

Parameters:
- ALU_OP_W, 3, width of the ALU_Op class input from the main control.
- ALU_CTRL_W, 5, width of the ALU operation code; must be at least 5.
- TIMEOUT_CYCLES, 40, maximum WAIT cycles before the watchdog fires; must be at least 1.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  the instruction in EX is valid.
- flush_i  in  1  pipeline flush; kills the EX instruction.
- ALU_Op_i  in  ALU_OP_W  class: R=000, I=001, U=010, LD/ST=011, B=100, J=101.
- funct7_i  in  7  instruction bits [31:25].
- funct3_i  in  3  instruction bits [14:12].
- mdu_done_i  in  1  MDU result ready (1-cycle pulse).
- ALU_Operation_o  out  ALU_CTRL_W  operation code.
- mdu_start_o  out  1  start pulse to the MDU.
- mdu_abort_o  out  1  abort pulse to the MDU.
- stall_o  out  1  holds IF/ID/EX.
- wb_sel_mdu_o  out  1  selects the MDU result into EX/MEM.
- illegal_o  out  1  unsupported encoding (combinational).
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Op codes (zero-extended to ALU_CTRL_W):
  - ADD 00000, SUB 00001, AND 00010, SRL 00011, XOR 00100, SRA 00101, SLT 00110, SLTU 00111.
  - LUI 01000, OR 01001, SLL 01100.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Decode rules:
  - R type: funct7 0000000 gives the base op by funct3; 0100000 with funct3 000 gives SUB, with 101 gives SRA; 0000001 gives an M op, code {2'b10, funct3}.
  - I type: by funct3. SLLI requires funct7=0000000; SRLI/SRAI are chosen by funct7 0000000/0100000.
  - U: LUI. LD/ST and J: ADD.
  - B type: beq/bne give SUB, blt/bge give SLT, bltu/bgeu give SLTU, funct3 010/011 are illegal.
  - Any other encoding: ADD with illegal_o=1. illegal_o is qualified by valid_i.
- is_m = R type, funct7=0000001 and valid_i.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - ALU_Operation_o is the combinational decode.
  - If is_m and not flush_i: mdu_start_o=1 and stall_o=1 (both combinational, same cycle), op_q latches the decode, cnt clears to 0, next state WAIT.
  - mdu_done_i is ignored in IDLE.
- WAIT:
  - stall_o=1, ALU_Operation_o=op_q; cnt increments each cycle, saturating.
  - If mdu_done_i: next DONE.
  - Else if cnt==TIMEOUT_CYCLES-1: timeout_o set (sticky until reset), mdu_abort_o=1 this cycle, next DONE.
- DONE:
  - Lasts 1 cycle: stall_o=0, wb_sel_mdu_o=1, ALU_Operation_o=op_q, next IDLE.
  - The EX instruction during DONE is still the same M op, so it is never re-issued.
- Latency: done sampled in WAIT at cycle k after start leads to DONE at k+1. Total stall = k+1 cycles.
- flush_i has highest priority in every state:
  - Next state IDLE.
  - mdu_start_o forced 0.
  - mdu_abort_o=1 if the current state is WAIT.
  - wb_sel_mdu_o forced 0.
- mdu_done_i and timeout in the same cycle: done wins, no timeout set.
- Reset (asserted at any time, including mid-WAIT):
  - State IDLE, op_q=0, cnt=0, timeout_o=0.
  - While reset is low, all outputs are 0, including ALU_Operation_o.
- Non-M ops never touch the FSM; their decode is purely combinational with zero latency.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op code localparams.
  - ALU_Op class codes.
  - funct7 constants (BASE, ALT, MEXT).
  - The FSM state encoding.
- Sub-module alu_decode: combinational {ALU_Op, funct7, funct3} to {op code, illegal, is_m}.
- Parent alu_control_seq owns the FSM, op_q, the watchdog counter and handshake outputs.

Test Plan:
- Base decode sweep: ADD/SUB/SRA/ORI/SLLI/SRLI/LUI/BLT with valid_i=1 -> codes 00000/00001/00101/01001/01100/00011/01000/00110 the same cycle, stall_o=0, illegal_o=0.
- Illegal: R type with funct7=0100000, funct3=001 -> ALU_Operation_o=00000, illegal_o=1; the same encoding with valid_i=0 -> illegal_o=0.
- MUL handshake: R type, funct7=0000001, funct3=000; mdu_done_i pulses 3 cycles after start -> mdu_start_o for 1 cycle, stall_o high 4 cycles, then wb_sel_mdu_o=1 for 1 cycle, ALU_Operation_o=10000 throughout, FSM back in IDLE.
- Watchdog: DIV issued with mdu_done_i never asserted, TIMEOUT_CYCLES=40 -> after 40 WAIT cycles mdu_abort_o pulses, DONE follows, timeout_o stays 1 until reset.
- Flush: flush_i at the 2nd WAIT cycle of REMU -> mdu_abort_o=1 that cycle, next cycle IDLE with stall_o=0 and wb_sel_mdu_o never asserted. flush_i in IDLE with an M op presented -> no mdu_start_o.
- Reset mid-WAIT: drop reset for 1 cycle during WAIT -> all outputs 0 immediately. After release, mdu_done_i=1 -> no wb_sel_mdu_o. A new MUL issues normally.
